// File: rtl/mips_pkg.sv
// Shared encodings for the multi-cycle MIPS control path: opcode/funct
// constants, sequencer states and the datapath select/operation codes.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  // Where the PC goes on an illegal-instruction trap.
  localparam logic [31:0] EXC_VECTOR = 32'h8000_0180;

  typedef enum logic [3:0] {
    S_RST      = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_EXEC_R   = 4'd3,
    S_JR       = 4'd4,
    S_EXEC_I   = 4'd5,
    S_MEM_ADDR = 4'd6,
    S_MEM_RD   = 4'd7,
    S_MEM_WR   = 4'd8,
    S_WB_R     = 4'd9,
    S_WB_I     = 4'd10,
    S_WB_MEM   = 4'd11,
    S_BRANCH   = 4'd12,
    S_JUMP     = 4'd13,
    S_EXC      = 4'd14
  } state_e;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_SLT = 4'd4,
    ALU_SLL = 4'd5,
    ALU_SRL = 4'd6,
    ALU_LUI = 4'd7
  } alu_op_e;

  typedef enum logic [1:0] {
    PC_ALU    = 2'd0,
    PC_ALUOUT = 2'd1,
    PC_JUMP   = 2'd2,
    PC_EXC    = 2'd3
  } pc_src_e;

  typedef enum logic [1:0] {
    RD_RT = 2'd0,
    RD_RD = 2'd1,
    RD_RA = 2'd2
  } reg_dst_e;

  typedef enum logic [1:0] {
    WB_ALUOUT = 2'd0,
    WB_MDR    = 2'd1,
    WB_PC     = 2'd2
  } wb_sel_e;

  typedef enum logic [1:0] {
    A_PC    = 2'd0,
    A_RS    = 2'd1,
    A_SHAMT = 2'd2
  } src_a_e;

  typedef enum logic [1:0] {
    B_RT     = 2'd0,
    B_FOUR   = 2'd1,
    B_IMM    = 2'd2,
    B_IMM_SH = 2'd3
  } src_b_e;

  function automatic logic is_shift(input logic [5:0] funct);
    return (funct == FN_SLL) || (funct == FN_SRL);
  endfunction

endpackage

// File: rtl/mc_ctrl_alu_ctrl.sv
// R-type funct decoder: maps funct to the ALU operation and flags encodings
// the core does not implement (JR is legal but handled by the sequencer).
module alu_ctrl
  import mips_pkg::*;
(
  input  logic [5:0] funct,
  output logic [3:0] alu_op,
  output logic       illegal
);

  always_comb begin
    alu_op  = ALU_ADD;
    illegal = 1'b0;
    case (funct)
      FN_ADD:  alu_op = ALU_ADD;
      FN_SUB:  alu_op = ALU_SUB;
      FN_AND:  alu_op = ALU_AND;
      FN_OR:   alu_op = ALU_OR;
      FN_SLT:  alu_op = ALU_SLT;
      FN_SLL:  alu_op = ALU_SLL;
      FN_SRL:  alu_op = ALU_SRL;
      FN_JR:   alu_op = ALU_ADD;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle control sequencer: registered state, control strobes decoded
// combinationally from state/op/funct. MCC_EXC_EN enables the illegal-op trap.
module mc_ctrl
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       alu_zero,
  input  logic       mem_ready,
  output logic       pc_we,
  output logic       ir_we,
  output logic       mem_req,
  output logic       mem_we,
  output logic       iord,
  output logic       reg_we,
  output logic [1:0] reg_dst,
  output logic [1:0] wb_sel,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       ext_sign,
  output logic [3:0] alu_op,
  output logic [1:0] pc_src,
  output logic       exc,
  output state_e     dbg_state
);

  state_e     state_q, state_d;
  logic [3:0] r_alu_op;
  logic       r_illegal;

`ifdef MCC_EXC_EN
  localparam state_e ILLEGAL_NEXT = S_EXC;
`else
  localparam state_e ILLEGAL_NEXT = S_FETCH;
`endif

  alu_ctrl u_alu_ctrl (
    .funct   (funct),
    .alu_op  (r_alu_op),
    .illegal (r_illegal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_RST;
    else        state_q <= state_d;
  end

  assign dbg_state = state_q;

  always_comb begin
    state_d   = state_q;
    pc_we     = 1'b0;
    ir_we     = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    iord      = 1'b0;
    reg_we    = 1'b0;
    reg_dst   = RD_RT;
    wb_sel    = WB_ALUOUT;
    alu_src_a = A_PC;
    alu_src_b = B_RT;
    ext_sign  = 1'b0;
    alu_op    = ALU_ADD;
    pc_src    = PC_ALU;
    exc       = 1'b0;

    case (state_q)
      S_RST: state_d = S_FETCH;

      // PC+4 is computed and written in the same cycle the word arrives.
      S_FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = B_FOUR;
        if (mem_ready) begin
          ir_we   = 1'b1;
          pc_we   = 1'b1;
          state_d = S_DECODE;
        end
      end

      S_DECODE: begin
        alu_src_b = B_IMM_SH;
        ext_sign  = 1'b1;
        case (op)
          OP_RTYPE: begin
            if (funct == FN_JR) state_d = S_JR;
            else if (r_illegal) state_d = ILLEGAL_NEXT;
            else                state_d = S_EXEC_R;
          end
          OP_ADDI, OP_ANDI, OP_ORI, OP_LUI: state_d = S_EXEC_I;
          OP_LW, OP_SW:                     state_d = S_MEM_ADDR;
          OP_BEQ, OP_BNE:                   state_d = S_BRANCH;
          OP_J, OP_JAL:                     state_d = S_JUMP;
          default:                          state_d = ILLEGAL_NEXT;
        endcase
      end

      S_EXEC_R: begin
        alu_src_a = is_shift(funct) ? A_SHAMT : A_RS;
        alu_src_b = B_RT;
        alu_op    = r_alu_op;
        state_d   = S_WB_R;
      end

      S_JR: begin
        alu_src_a = A_RS;
        alu_src_b = B_FOUR;
        alu_op    = ALU_SUB;
        pc_src    = PC_ALU;
        pc_we     = 1'b1;
        state_d   = S_FETCH;
      end

      S_EXEC_I: begin
        alu_src_a = A_RS;
        alu_src_b = B_IMM;
        case (op)
          OP_ADDI: begin ext_sign = 1'b1; alu_op = ALU_ADD; end
          OP_ANDI: alu_op = ALU_AND;
          OP_ORI:  alu_op = ALU_OR;
          default: alu_op = ALU_LUI;
        endcase
        state_d = S_WB_I;
      end

      S_MEM_ADDR: begin
        alu_src_a = A_RS;
        alu_src_b = B_IMM;
        ext_sign  = 1'b1;
        state_d   = (op == OP_LW) ? S_MEM_RD : S_MEM_WR;
      end

      S_MEM_RD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        if (mem_ready) state_d = S_WB_MEM;
      end

      S_MEM_WR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        iord    = 1'b1;
        if (mem_ready) state_d = S_FETCH;
      end

      S_WB_R: begin
        reg_we  = 1'b1;
        reg_dst = RD_RD;
        state_d = S_FETCH;
      end

      S_WB_I: begin
        reg_we  = 1'b1;
        state_d = S_FETCH;
      end

      S_WB_MEM: begin
        reg_we  = 1'b1;
        wb_sel  = WB_MDR;
        state_d = S_FETCH;
      end

      // ALUOut holds the target computed during DECODE.
      S_BRANCH: begin
        alu_src_a = A_RS;
        alu_src_b = B_RT;
        alu_op    = ALU_SUB;
        pc_src    = PC_ALUOUT;
        pc_we     = (op == OP_BEQ) ? alu_zero : !alu_zero;
        state_d   = S_FETCH;
      end

      S_JUMP: begin
        pc_src = PC_JUMP;
        pc_we  = 1'b1;
        if (op == OP_JAL) begin
          reg_we  = 1'b1;
          reg_dst = RD_RA;
          wb_sel  = WB_PC;
        end
        state_d = S_FETCH;
      end

`ifdef MCC_EXC_EN
      S_EXC: begin
        exc     = 1'b1;
        pc_src  = PC_EXC;
        pc_we   = 1'b1;
        state_d = S_FETCH;
      end
`endif

      default: state_d = S_FETCH;
    endcase
  end

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl: walks each instruction class through the
// sequencer and checks state and every strobe with immediate assertions.
module tb_mc_ctrl;
  import mips_pkg::*;

  typedef struct packed {
    logic       pc_we;
    logic       ir_we;
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       reg_we;
    logic [1:0] reg_dst;
    logic [1:0] wb_sel;
    logic [1:0] src_a;
    logic [1:0] src_b;
    logic       ext_sign;
    logic [3:0] alu_op;
    logic [1:0] pc_src;
    logic       exc;
  } ctl_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] op, funct;
  logic       alu_zero, mem_ready;
  logic       pc_we, ir_we, mem_req, mem_we, iord, reg_we, ext_sign, exc;
  logic [1:0] reg_dst, wb_sel, alu_src_a, alu_src_b, pc_src;
  logic [3:0] alu_op;
  state_e     dbg_state;

  ctl_t obs, e;
  int   total = 0;
  int   bad   = 0;

  assign obs = {pc_we, ir_we, mem_req, mem_we, iord, reg_we, reg_dst, wb_sel,
                alu_src_a, alu_src_b, ext_sign, alu_op, pc_src, exc};

  always #5 clk = ~clk;

  mc_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .op        (op),
    .funct     (funct),
    .alu_zero  (alu_zero),
    .mem_ready (mem_ready),
    .pc_we     (pc_we),
    .ir_we     (ir_we),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .iord      (iord),
    .reg_we    (reg_we),
    .reg_dst   (reg_dst),
    .wb_sel    (wb_sel),
    .alu_src_a (alu_src_a),
    .alu_src_b (alu_src_b),
    .ext_sign  (ext_sign),
    .alu_op    (alu_op),
    .pc_src    (pc_src),
    .exc       (exc),
    .dbg_state (dbg_state)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input state_e es, input ctl_t ec);
    #1;
    total++;
    assert (dbg_state === es) else begin
      bad++;
      $error("FAIL %s state obs=%0d exp=%0d", tag, dbg_state, es);
    end
    total++;
    assert (obs === ec) else begin
      bad++;
      $error("FAIL %s ctl obs=%h exp=%h", tag, obs, ec);
    end
  endtask

  function automatic ctl_t fetch_exp(input logic rdy);
    ctl_t c = '0;
    c.mem_req = 1'b1;
    c.src_b   = 2'd1;
    c.pc_we   = rdy;
    c.ir_we   = rdy;
    return c;
  endfunction

  function automatic ctl_t dec_exp();
    ctl_t c = '0;
    c.src_b    = 2'd3;
    c.ext_sign = 1'b1;
    return c;
  endfunction

  initial begin
    rst_n = 1'b0; op = 6'h00; funct = 6'h00; alu_zero = 1'b0; mem_ready = 1'b1;
    repeat (2) tick();
    chk("reset", S_RST, '0);
    rst_n = 1'b1;
    chk("reset_release", S_RST, '0);

    // add $3,$1,$2 (0x00221820)
    op = 6'h00; funct = 6'h20;
    tick(); chk("add_fetch", S_FETCH, fetch_exp(1'b1));
    tick(); chk("add_decode", S_DECODE, dec_exp());
    tick(); e = '0; e.src_a = 2'd1; chk("add_exec", S_EXEC_R, e);
    tick(); e = '0; e.reg_we = 1'b1; e.reg_dst = 2'd1; chk("add_wb", S_WB_R, e);
    tick(); chk("add_next_fetch", S_FETCH, fetch_exp(1'b1));

    // fetch stall
    mem_ready = 1'b0;
    chk("fetch_stall0", S_FETCH, fetch_exp(1'b0));
    tick(); chk("fetch_stall1", S_FETCH, fetch_exp(1'b0));
    mem_ready = 1'b1; funct = 6'h00;
    tick(); chk("sll_decode", S_DECODE, dec_exp());
    tick(); e = '0; e.src_a = 2'd2; e.alu_op = 4'd5; chk("sll_exec", S_EXEC_R, e);
    tick(); tick();

    // slt and srl
    funct = 6'h2A;
    tick(); tick(); e = '0; e.src_a = 2'd1; e.alu_op = 4'd4; chk("slt_exec", S_EXEC_R, e);
    tick(); tick();
    funct = 6'h02;
    tick(); tick(); e = '0; e.src_a = 2'd2; e.alu_op = 4'd6; chk("srl_exec", S_EXEC_R, e);
    tick(); tick();

    // lw $2,4($1) with two memory wait cycles
    op = 6'h23; funct = 6'h04;
    tick(); chk("lw_decode", S_DECODE, dec_exp());
    tick(); e = '0; e.src_a = 2'd1; e.src_b = 2'd2; e.ext_sign = 1'b1;
    mem_ready = 1'b0;
    chk("lw_addr", S_MEM_ADDR, e);
    e = '0; e.mem_req = 1'b1; e.iord = 1'b1;
    tick(); chk("lw_rd_wait0", S_MEM_RD, e);
    tick(); chk("lw_rd_wait1", S_MEM_RD, e);
    mem_ready = 1'b1;
    chk("lw_rd_done", S_MEM_RD, e);
    tick(); e = '0; e.reg_we = 1'b1; e.wb_sel = 2'd1; chk("lw_wb", S_WB_MEM, e);
    tick(); chk("lw_next_fetch", S_FETCH, fetch_exp(1'b1));

    // addi / ori / lui
    op = 6'h08; funct = 6'h00;
    tick(); tick();
    e = '0; e.src_a = 2'd1; e.src_b = 2'd2; e.ext_sign = 1'b1; chk("addi_exec", S_EXEC_I, e);
    tick(); e = '0; e.reg_we = 1'b1; chk("addi_wb", S_WB_I, e);
    tick();
    op = 6'h0D;
    tick(); tick(); e = '0; e.src_a = 2'd1; e.src_b = 2'd2; e.alu_op = 4'd3; chk("ori_exec", S_EXEC_I, e);
    tick(); tick();
    op = 6'h0F;
    tick(); tick(); e = '0; e.src_a = 2'd1; e.src_b = 2'd2; e.alu_op = 4'd7; chk("lui_exec", S_EXEC_I, e);
    tick(); tick();

    // beq both outcomes
    op = 6'h04; alu_zero = 1'b1;
    tick(); tick();
    e = '0; e.src_a = 2'd1; e.alu_op = 4'd1; e.pc_src = 2'd1; e.pc_we = 1'b1;
    chk("beq_taken", S_BRANCH, e);
    alu_zero = 1'b0; e.pc_we = 1'b0;
    chk("beq_not_taken", S_BRANCH, e);
    tick(); chk("beq_next_fetch", S_FETCH, fetch_exp(1'b1));

    // bne both outcomes
    op = 6'h05;
    tick(); tick();
    e = '0; e.src_a = 2'd1; e.alu_op = 4'd1; e.pc_src = 2'd1; e.pc_we = 1'b1;
    chk("bne_taken", S_BRANCH, e);
    alu_zero = 1'b1; e.pc_we = 1'b0;
    chk("bne_not_taken", S_BRANCH, e);
    alu_zero = 1'b0;
    tick();

    // jal 0x0C000010, then j
    op = 6'h03; funct = 6'h10;
    tick(); tick();
    e = '0; e.pc_src = 2'd2; e.pc_we = 1'b1; e.reg_we = 1'b1; e.reg_dst = 2'd2; e.wb_sel = 2'd2;
    chk("jal_jump", S_JUMP, e);
    tick(); chk("jal_next_fetch", S_FETCH, fetch_exp(1'b1));
    op = 6'h02;
    tick(); tick(); e = '0; e.pc_src = 2'd2; e.pc_we = 1'b1; chk("j_jump", S_JUMP, e);
    tick();

    // jr
    op = 6'h00; funct = 6'h08;
    tick(); tick();
    e = '0; e.pc_we = 1'b1; e.src_a = 2'd1; e.src_b = 2'd1; e.alu_op = 4'd1;
    chk("jr", S_JR, e);
    tick(); chk("jr_next_fetch", S_FETCH, fetch_exp(1'b1));

    // unsupported opcode and unsupported funct
    op = 6'h3F; funct = 6'h00;
    tick(); chk("badop_decode", S_DECODE, dec_exp());
    tick();
`ifdef MCC_EXC_EN
    e = '0; e.exc = 1'b1; e.pc_src = 2'd3; e.pc_we = 1'b1; chk("badop_exc", S_EXC, e);
    tick();
`endif
    chk("badop_fetch", S_FETCH, fetch_exp(1'b1));
    op = 6'h00; funct = 6'h3F;
    tick(); tick();
`ifdef MCC_EXC_EN
    e = '0; e.exc = 1'b1; e.pc_src = 2'd3; e.pc_we = 1'b1; chk("badfn_exc", S_EXC, e);
    tick();
`endif
    chk("badfn_fetch", S_FETCH, fetch_exp(1'b1));

    // sw interrupted by reset while waiting on memory
    op = 6'h2B; funct = 6'h00;
    tick(); tick();
    e = '0; e.src_a = 2'd1; e.src_b = 2'd2; e.ext_sign = 1'b1; chk("sw_addr", S_MEM_ADDR, e);
    mem_ready = 1'b0;
    tick(); e = '0; e.mem_req = 1'b1; e.mem_we = 1'b1; e.iord = 1'b1; chk("sw_wr_wait", S_MEM_WR, e);
    rst_n = 1'b0;
    chk("sw_async_reset", S_RST, '0);
    tick(); chk("reset_hold", S_RST, '0);
    rst_n = 1'b1;
    chk("reset_release2", S_RST, '0);
    tick(); chk("fetch_after_reset", S_FETCH, fetch_exp(1'b0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
